maze_env_step: RTL and testbench

- Stateful, parametrised grid-maze environment for the Q-learning datapath.
- Holds the agent's current cell and accepts one action per valid/ready handshake.
- Returns the next cell, a signed reward, and bump/done/timeout flags on a valid/ready result channel.
- Sits between the action-selection block and the Q-table update block; replaces fixed 6x6, list-of-blocked-cells step logic with a bitmap-driven ROWSxCOLS grid.

---
 rtl/maze_pkg.sv | 31 +++
 rtl/maze_move_check.sv | 67 ++++++
 rtl/maze_env_step.sv | 162 ++++++++++++++++
 tb/tb_maze_env_step.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// maze_pkg: shared types and constants for the grid-maze environment.
//   action_t    : agent move encoding (down/right/up/left)
//   fsm_state_t : step-engine control states
//   DEF_R_*     : default reward constants
//   state_width : bits needed to hold cell numbers 0..cells
package maze_pkg;

    typedef enum logic [1:0] {
        ACT_DOWN  = 2'd0,
        ACT_RIGHT = 2'd1,
        ACT_UP    = 2'd2,
        ACT_LEFT  = 2'd3
    } action_t;

    typedef enum logic [1:0] {
        ST_LOAD     = 2'd0,
        ST_WAIT_ACT = 2'd1,
        ST_EVAL     = 2'd2,
        ST_RESP     = 2'd3
    } fsm_state_t;

    localparam int DEF_R_GOAL = 100;
    localparam int DEF_R_BUMP = -5;
    localparam int DEF_R_STEP = -1;

    // Cell 0 is reserved as "invalid", so the width must cover cells+1 codes.
    function automatic int state_width(input int cells);
        return $clog2(cells + 1);
    endfunction

endpackage

// File: rtl/maze_move_check.sv
// maze_move_check: combinational move legality for one agent step.
//   cur         : current cell (1..ROWS*COLS, row-major)
//   action      : requested move
//   blocked_map : bit i set = cell i blocked (bit 0 ignored in practice)
//   cand        : candidate cell after the move (valid when legal)
//   legal       : move stays on the grid and does not enter a blocked cell
module maze_move_check
    import maze_pkg::*;
#(
    parameter int ROWS = 6,
    parameter int COLS = 6,
    parameter int SW   = state_width(ROWS * COLS)
) (
    input  logic [SW-1:0]      cur,
    input  action_t            action,
    input  logic [ROWS*COLS:0] blocked_map,
    output logic [SW-1:0]      cand,
    output logic               legal
);

    // One extra bit so cur+COLS / cur-COLS never wrap before the edge test.
    localparam int XW = SW + 1;
    localparam logic [XW-1:0] COLS_X        = XW'(COLS);
    localparam logic [XW-1:0] COL_LAST      = XW'(COLS - 1);
    localparam logic [XW-1:0] LAST_ROW_BASE = XW'((ROWS - 1) * COLS);
    localparam logic [ROWS*COLS:0] ONE_HOT0 = 1;

    logic [XW-1:0] idx;     // zero-based cell index
    logic [XW-1:0] col;
    logic [XW-1:0] cand_x;
    logic          edge_ok;
    logic          blk;

    always_comb begin
        idx     = {1'b0, cur} - XW'(1);
        col     = idx % COLS_X;
        cand_x  = {1'b0, cur};
        edge_ok = 1'b0;
        case (action)
            ACT_DOWN: begin
                cand_x  = {1'b0, cur} + COLS_X;
                edge_ok = (idx < LAST_ROW_BASE);
            end
            ACT_RIGHT: begin
                cand_x  = {1'b0, cur} + XW'(1);
                edge_ok = (col != COL_LAST);
            end
            ACT_UP: begin
                cand_x  = {1'b0, cur} - COLS_X;
                edge_ok = (idx >= COLS_X);
            end
            ACT_LEFT: begin
                cand_x  = {1'b0, cur} - XW'(1);
                edge_ok = (col != '0);
            end
            default: begin
                cand_x  = {1'b0, cur};
                edge_ok = 1'b0;
            end
        endcase
        // Shifted one-hot lookup: an off-grid candidate simply misses the map.
        blk   = |(blocked_map & (ONE_HOT0 << cand_x));
        legal = edge_ok && !blk;
        cand  = cand_x[SW-1:0];
    end

endmodule

// File: rtl/maze_env_step.sv
// maze_env_step: stateful ROWSxCOLS grid-maze environment, one action per step.
//   clk, rst (async, active low)
//   start_state/target_state : episode start cell and goal cell
//   blocked_map              : per-cell blocked bitmap, sampled during EVAL
//   act_valid/act_ready/action                 : action channel
//   res_valid/res_ready, next_state, reward,
//   bumped, episode_done, timeout               : result channel
//   cur_state, step_count, episode_count        : environment state
// Optional build macro MAZE_STEP_LIMIT_EN: end an episode with timeout once
// MAX_STEPS steps are taken without reaching the goal.
module maze_env_step
    import maze_pkg::*;
#(
    parameter int ROWS      = 6,
    parameter int COLS      = 6,
    parameter int RW        = 16,
    parameter int R_GOAL    = DEF_R_GOAL,
    parameter int R_BUMP    = DEF_R_BUMP,
    parameter int R_STEP    = DEF_R_STEP,
    parameter int CW        = 16,
    parameter int MAX_STEPS = 64,
    // Derived from the grid size; not meant to be overridden.
    parameter int SW        = state_width(ROWS * COLS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SW-1:0]        start_state,
    input  logic [SW-1:0]        target_state,
    input  logic [ROWS*COLS:0]   blocked_map,
    input  logic                 act_valid,
    output logic                 act_ready,
    input  logic [1:0]           action,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [SW-1:0]        cur_state,
    output logic [SW-1:0]        next_state,
    output logic signed [RW-1:0] reward,
    output logic                 bumped,
    output logic                 episode_done,
    output logic                 timeout,
    output logic [CW-1:0]        step_count,
    output logic [CW-1:0]        episode_count
);

`ifdef MAZE_STEP_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    localparam logic signed [RW-1:0] RV_GOAL   = RW'(R_GOAL);
    localparam logic signed [RW-1:0] RV_BUMP   = RW'(R_BUMP);
    localparam logic signed [RW-1:0] RV_STEP   = RW'(R_STEP);
    localparam logic [CW-1:0]        LAST_STEP = CW'(MAX_STEPS - 1);

    fsm_state_t state, state_nxt;
    action_t    act_q;

    logic [SW-1:0]        cand;
    logic                 legal;
    logic                 at_goal;
    logic                 reach_goal;
    logic                 hit_limit;
    logic [SW-1:0]        ev_next;
    logic signed [RW-1:0] ev_reward;
    logic                 ev_bump;

    maze_move_check #(
        .ROWS (ROWS),
        .COLS (COLS),
        .SW   (SW)
    ) u_move (
        .cur         (cur_state),
        .action      (act_q),
        .blocked_map (blocked_map),
        .cand        (cand),
        .legal       (legal)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_LOAD;
        else      state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:     state_nxt = ST_WAIT_ACT;
            ST_WAIT_ACT: if (act_valid) state_nxt = ST_EVAL;
            ST_EVAL:     state_nxt = ST_RESP;
            ST_RESP:     if (res_ready) state_nxt = ST_WAIT_ACT;
            default:     state_nxt = ST_LOAD;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        act_ready = (state == ST_WAIT_ACT);
        res_valid = (state == ST_RESP);
    end

    // ---------------- step evaluation ----------------
    always_comb begin
        // Start == target: the agent is already home, so no move is made.
        at_goal    = (cur_state == target_state);
        reach_goal = !at_goal && legal && (cand == target_state);
        hit_limit  = LIMIT_EN && (step_count == LAST_STEP) && !(at_goal || reach_goal);
        ev_bump    = !at_goal && !legal;
        ev_next    = (!at_goal && legal) ? cand : cur_state;
        if (at_goal || reach_goal) ev_reward = RV_GOAL;
        else if (ev_bump)          ev_reward = RV_BUMP;
        else                       ev_reward = RV_STEP;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_q         <= ACT_DOWN;
            cur_state     <= '0;
            next_state    <= '0;
            reward        <= '0;
            bumped        <= 1'b0;
            episode_done  <= 1'b0;
            timeout       <= 1'b0;
            step_count    <= '0;
            episode_count <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    cur_state  <= start_state;
                    step_count <= '0;
                end
                ST_WAIT_ACT: begin
                    if (act_valid) act_q <= action_t'(action);
                end
                ST_EVAL: begin
                    next_state   <= ev_next;
                    reward       <= ev_reward;
                    bumped       <= ev_bump;
                    episode_done <= at_goal || reach_goal || hit_limit;
                    timeout      <= hit_limit;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        if (episode_done) begin
                            cur_state     <= start_state;
                            step_count    <= '0;
                            episode_count <= episode_count + CW'(1);
                        end else begin
                            cur_state <= next_state;
                            if (step_count != '1) step_count <= step_count + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_env_step.sv
// tb_maze_env_step: directed table, hand sequences and randomized steps
// checked against a row/column reference model of the maze.
module tb_maze_env_step;

    localparam int ROWS = 6;
    localparam int COLS = 6;
    localparam int RW   = 16;
    localparam int CW   = 16;
    localparam int MAXS = 4;
    localparam int SW   = 6;
    localparam int NC   = ROWS * COLS;

    logic                 clk;
    logic                 rst;
    logic [SW-1:0]        start_state;
    logic [SW-1:0]        target_state;
    logic [NC:0]          blocked_map;
    logic                 act_valid;
    logic                 act_ready;
    logic [1:0]           action;
    logic                 res_valid;
    logic                 res_ready;
    logic [SW-1:0]        cur_state;
    logic [SW-1:0]        next_state;
    logic signed [RW-1:0] reward;
    logic                 bumped;
    logic                 episode_done;
    logic                 timeout;
    logic [CW-1:0]        step_count;
    logic [CW-1:0]        episode_count;

    int n_chk = 0;
    int n_fail = 0;

    maze_env_step #(
        .ROWS(ROWS), .COLS(COLS), .RW(RW), .R_GOAL(100), .R_BUMP(-5), .R_STEP(-1),
        .CW(CW), .MAX_STEPS(MAXS)
    ) dut (
        .clk(clk), .rst(rst), .start_state(start_state), .target_state(target_state),
        .blocked_map(blocked_map), .act_valid(act_valid), .act_ready(act_ready),
        .action(action), .res_valid(res_valid), .res_ready(res_ready),
        .cur_state(cur_state), .next_state(next_state), .reward(reward), .bumped(bumped),
        .episode_done(episode_done), .timeout(timeout), .step_count(step_count),
        .episode_count(episode_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: move in (row, col) space, then map back to a cell number.
    function automatic void model_eval(input int cur, input int a, input int target,
                                       input logic [NC:0] blk, input int step,
                                       output int nxt, output int rew,
                                       output bit bump, output bit done, output bit to);
        int r, c, nr, nc, cand;
        bit goal;
        r = (cur - 1) / COLS;
        c = (cur - 1) % COLS;
        nr = r;
        nc = c;
        case (a)
            0: nr = r + 1;
            1: nc = c + 1;
            2: nr = r - 1;
            default: nc = c - 1;
        endcase
        bump = 0;
        goal = 0;
        nxt  = cur;
        if (cur == target) goal = 1;
        else if (nr < 0 || nr >= ROWS || nc < 0 || nc >= COLS) bump = 1;
        else begin
            cand = nr * COLS + nc + 1;
            if (blk[cand]) bump = 1;
            else begin
                nxt  = cand;
                goal = (cand == target);
            end
        end
        rew = goal ? 100 : (bump ? -5 : -1);
        to = 0;
`ifdef MAZE_STEP_LIMIT_EN
        if (!goal && step == MAXS - 1) to = 1;
`endif
        done = goal || to;
    endfunction

    task automatic do_reset(input int s, input int t, input logic [NC:0] b);
        @(negedge clk);
        rst = 1'b0;
        start_state  = SW'(s);
        target_state = SW'(t);
        blocked_map  = b;
        act_valid = 1'b0;
        res_ready = 1'b0;
        #1;
        chk("reset_ctl", {act_ready, res_valid, cur_state, next_state, bumped, episode_done, timeout}, 0);
        chk("reset_data", {reward, step_count, episode_count}, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One full action/result exchange, checking latency, held results and post-handshake state.
    task automatic run_step(input int a, input int hold,
                            input int e_next, input int e_rew, input bit e_bump,
                            input bit e_done, input bit e_to,
                            input int e_cur, input int e_step, input int e_ep);
        int w;
        w = 0;
        @(negedge clk);
        while (!act_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!act_ready) begin
            chk("act_ready_wait", act_ready, 1);
            return;
        end
        action = 2'(a);
        act_valid = 1'b1;
        @(negedge clk);
        act_valid = 1'b0;
        chk("lat_n1_res_valid", res_valid, 0);
        chk("lat_n1_act_ready", act_ready, 0);
        @(negedge clk);
        chk("lat_n2_res_valid", res_valid, 1);
        for (int h = 0; h <= hold; h++) begin
            chk("next_state", next_state, e_next);
            chk("reward", reward, e_rew);
            chk("bumped", bumped, e_bump);
            chk("episode_done", episode_done, e_done);
            chk("timeout", timeout, e_to);
            chk("hold_act_ready", act_ready, 0);
            chk("hold_res_valid", res_valid, 1);
            if (h < hold) @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("after_res_valid", res_valid, 0);
        chk("after_cur_state", cur_state, e_cur);
        chk("after_step_count", step_count, e_step);
        chk("after_episode_count", episode_count, e_ep);
    endtask

    typedef struct {
        int          start;
        int          target;
        logic [NC:0] blk;
        int          act;
        int          e_next;
        int          e_rew;
        bit          e_bump;
        bit          e_done;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int m_cur, m_step, m_ep, m_start, m_target;
        logic [NC:0] m_blk;
        int nxt, rew;
        bit bump, done, to;
        int w;

        rst = 1'b0;
        start_state = '0;
        target_state = '0;
        blocked_map = '0;
        act_valid = 1'b0;
        action = '0;
        res_ready = 1'b0;

        // Each entry runs one step from a fresh episode starting at 'start'.
        tbl[0]  = '{1,  36, 37'h0,      0, 7,  -1,  0, 0};
        tbl[1]  = '{6,  36, 37'h0,      1, 6,  -5,  1, 0};
        tbl[2]  = '{7,  36, 37'h0,      3, 7,  -5,  1, 0};
        tbl[3]  = '{7,  36, 37'h100,    1, 7,  -5,  1, 0};
        tbl[4]  = '{30, 36, 37'h0,      0, 36, 100, 0, 1};
        tbl[5]  = '{1,  36, 37'h0,      2, 1,  -5,  1, 0};
        tbl[6]  = '{31, 36, 37'h0,      0, 31, -5,  1, 0};
        tbl[7]  = '{36, 36, 37'h0,      3, 36, 100, 0, 1};
        tbl[8]  = '{35, 36, 37'h0,      1, 36, 100, 0, 1};
        tbl[9]  = '{15, 9,  37'h0,      2, 9,  100, 0, 1};
        tbl[10] = '{14, 36, 37'h8000,   1, 14, -5,  1, 0};
        tbl[11] = '{14, 20, 37'h100000, 0, 14, -5,  1, 0};
        tbl[12] = '{12, 36, 37'h0,      1, 12, -5,  1, 0};
        tbl[13] = '{13, 36, 37'h0,      3, 13, -5,  1, 0};
        tbl[14] = '{2,  36, 37'h0,      3, 1,  -1,  0, 0};

        for (int i = 0; i < 15; i++) begin
            do_reset(tbl[i].start, tbl[i].target, tbl[i].blk);
            run_step(tbl[i].act, i % 3, tbl[i].e_next, tbl[i].e_rew, tbl[i].e_bump,
                     tbl[i].e_done, 1'b0,
                     tbl[i].e_done ? tbl[i].start : tbl[i].e_next,
                     tbl[i].e_done ? 0 : 1, tbl[i].e_done ? 1 : 0);
        end

        // Result held while the consumer stalls for 5 cycles.
        do_reset(1, 36, '0);
        run_step(0, 5, 7, -1, 0, 0, 0, 7, 1, 0);

        // Reset while a result is pending: it is dropped and the episode reloads.
        do_reset(1, 36, '0);
        w = 0;
        @(negedge clk);
        while (!act_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        action = 2'd1;
        act_valid = 1'b1;
        @(negedge clk);
        act_valid = 1'b0;
        @(negedge clk);
        chk("midrst_res_valid_before", res_valid, 1);
        #2;
        rst = 1'b0;
        start_state = SW'(10);
        #1;
        chk("midrst_res_valid_async", res_valid, 0);
        chk("midrst_cur_state", cur_state, 0);
        @(negedge clk);
        rst = 1'b1;
        w = 0;
        @(negedge clk);
        while (!act_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("midrst_act_ready", act_ready, 1);
        chk("midrst_reload_cur", cur_state, 10);
        chk("midrst_reload_step", step_count, 0);

        // Four non-goal moves: the fourth hits the step limit when it is enabled.
        do_reset(1, 36, '0);
        run_step(1, 0, 2, -1, 0, 0, 0, 2, 1, 0);
        run_step(1, 0, 3, -1, 0, 0, 0, 3, 2, 0);
        run_step(1, 0, 4, -1, 0, 0, 0, 4, 3, 0);
`ifdef MAZE_STEP_LIMIT_EN
        run_step(1, 0, 5, -1, 0, 1, 1, 1, 0, 1);
`else
        run_step(1, 0, 5, -1, 0, 0, 0, 5, 4, 0);
`endif

        // Randomized episodes against the reference model.
        for (int ep = 0; ep < 4; ep++) begin
            m_start  = $urandom_range(1, NC);
            m_target = $urandom_range(1, NC);
            m_blk    = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            do_reset(m_start, m_target, m_blk);
            m_cur = m_start;
            m_step = 0;
            m_ep = 0;
            for (int s = 0; s < 60; s++) begin
                if ($urandom_range(0, 7) == 0) begin
                    m_blk = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                    blocked_map = m_blk;
                end
                if ($urandom_range(0, 9) == 0) begin
                    m_start = $urandom_range(1, NC);
                    start_state = SW'(m_start);
                end
                begin
                    int a;
                    a = $urandom_range(0, 3);
                    model_eval(m_cur, a, m_target, m_blk, m_step, nxt, rew, bump, done, to);
                    if (done) begin
                        m_cur = m_start;
                        m_step = 0;
                        m_ep++;
                    end else begin
                        m_cur = nxt;
                        m_step++;
                    end
                    run_step(a, $urandom_range(0, 2), nxt, rew, bump, done, to, m_cur, m_step, m_ep);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
